// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and datapath.
// Holds state codes, opcodes and the datapath select encodings.
package mc_ctrl_pkg;

  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_I_EXEC   = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  // States whose exit into FETCH retires an instruction.
  function automatic logic is_retire(input logic [3:0] s);
    return (s == S_MEM_WB) || (s == S_MEM_WR) ||
           (s == S_R_WB)   || (s == S_BRANCH) ||
           (s == S_JUMP)   || (s == S_I_WB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with memory stall.
// In: clk_i, rst_i (async low), instr_op_i, mem_ready_i. Out: selects, strobes, state_o, instr_cnt_o.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       pc_source_o,
  output logic             ext_sign_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (instr_op_i)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE:        state_d = S_R_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI, OP_ORI: state_d = S_I_EXEC;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:
        state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WB: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready_i) state_d = S_FETCH;
      S_R_EXEC: state_d = S_R_WB;
      S_R_WB:   state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_I_EXEC: state_d = S_I_WB;
      S_I_WB:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_REG;
    alu_op_o        = ALU_ADD;
    pc_source_o     = PCS_ALU;
    ext_sign_o      = 1'b1;
    illegal_o       = 1'b0;
    case (state_q)
      S_RESET: ext_sign_o = 1'b0;
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        // IR and PC only load once the fetch read completes.
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM2;
        case (instr_op_i)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ,
          OP_J, OP_ADDI, OP_ORI: illegal_o = 1'b0;
          default:               illegal_o = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = PCS_ALUOUT;
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCS_JUMP;
      end
      S_I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        // ori zero-extends its immediate and ORs.
        if (instr_op_i == OP_ORI) begin
          alu_op_o   = ALU_OR;
          ext_sign_o = 1'b0;
        end
      end
      S_I_WB: reg_write_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (is_retire(state_q) && state_d == S_FETCH)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o     = state_q;
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl.
// Uses a 4-bit counter so the wrap is reachable quickly.
module tb_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       rdy;
  logic       pcw, pcwc, iord, mrd, mwr, irw;
  logic       rdst, m2r, rw, srca, exts, ill;
  logic [1:0] srcb, aop, pcs;
  logic [3:0] st;
  logic [3:0] cnt;

  int n_vec;
  int n_err;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .instr_op_i     (op),
    .mem_ready_i    (rdy),
    .pc_write_o     (pcw),
    .pc_write_cond_o(pcwc),
    .iord_o         (iord),
    .mem_read_o     (mrd),
    .mem_write_o    (mwr),
    .ir_write_o     (irw),
    .reg_dst_o      (rdst),
    .mem_to_reg_o   (m2r),
    .reg_write_o    (rw),
    .alu_src_a_o    (srca),
    .alu_src_b_o    (srcb),
    .alu_op_o       (aop),
    .pc_source_o    (pcs),
    .ext_sign_o     (exts),
    .illegal_o      (ill),
    .state_o        (st),
    .instr_cnt_o    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] all_out();
    return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw,
            srca, srcb, aop, pcs, exts, ill, st};
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    rdy   = 1'b1;
    op    = 6'h00;

    repeat (3) step();
    chk("rst_outs", 32'(all_out()), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);

    rst_n = 1'b1;
    chk("rel_state", 32'(st), 32'd0);
    step();
    chk("fetch_state", 32'(st), 32'd1);
    chk("fetch_strb", {29'd0, mrd, irw, pcw}, 32'h7);
    chk("fetch_srcb", 32'(srcb), 32'd1);

    // Fetch wait: load strobes drop, state holds.
    rdy = 1'b0;
    #1;
    chk("fwait_strb", {29'd0, mrd, irw, pcw}, 32'h4);
    step();
    chk("fwait_state", 32'(st), 32'd1);
    rdy = 1'b1;

    // lw with two MEM_RD wait cycles: 7 cycles total.
    op = 6'h23;
    step();
    chk("lw_dec", 32'(st), 32'd2);
    chk("lw_dec_sel", {28'd0, srca, srcb, exts}, {28'd0, 4'b0111});
    step();
    chk("lw_addr", {26'd0, st, srca, srcb[1]}, {26'd0, 4'd3, 2'b11});
    step();
    rdy = 1'b0;
    #1;
    chk("lw_rd", {27'd0, st, mrd}, {27'd0, 4'd4, 1'b1});
    chk("lw_iord", 32'(iord), 32'd1);
    step();
    chk("lw_rd_w2", 32'(st), 32'd4);
    step();
    rdy = 1'b1;
    chk("lw_rd_w3", 32'(st), 32'd4);
    step();
    chk("lw_wb", {26'd0, st, rw, m2r}, {26'd0, 4'd5, 2'b11});
    chk("lw_wb_cnt", 32'(cnt), 32'd0);
    step();
    chk("lw_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd1});

    // ori then addi.
    op = 6'h0D;
    step();
    step();
    chk("ori_ex", {25'd0, st, aop, exts}, {25'd0, 4'd11, 2'b11, 1'b0});
    step();
    chk("ori_wb", {25'd0, st, rw, rdst, m2r}, {25'd0, 4'd12, 3'b100});
    step();
    chk("ori_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd2});
    op = 6'h08;
    step();
    step();
    chk("addi_ex", {25'd0, st, aop, exts}, {25'd0, 4'd11, 2'b00, 1'b1});
    step();
    step();
    chk("addi_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd3});

    // beq then j.
    op = 6'h04;
    step();
    step();
    chk("beq_br", {23'd0, st, pcwc, pcs, aop},
        {23'd0, 4'd9, 1'b1, 2'b01, 2'b01});
    step();
    chk("beq_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd4});
    op = 6'h02;
    step();
    step();
    chk("j_jmp", {25'd0, st, pcw, pcs}, {25'd0, 4'd10, 1'b1, 2'b10});
    step();
    chk("j_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd5});

    // R-type.
    op = 6'h00;
    step();
    step();
    chk("r_ex", {26'd0, st, aop}, {26'd0, 4'd7, 2'b10});
    step();
    chk("r_wb", {26'd0, st, rw, rdst}, {26'd0, 4'd8, 2'b11});
    step();
    chk("r_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd6});

    // Illegal opcode.
    op = 6'h3F;
    step();
    chk("ill_dec", {27'd0, st, ill}, {27'd0, 4'd2, 1'b1});
    step();
    chk("ill_back", {23'd0, st, ill, cnt}, {23'd0, 4'd1, 1'b0, 4'd6});

    // Nine jumps take the counter to all-ones, one more wraps it.
    op = 6'h02;
    for (int i = 0; i < 9; i++) repeat (3) step();
    chk("cnt_max", {24'd0, st, cnt}, {24'd0, 4'd1, 4'hF});
    repeat (3) step();
    chk("cnt_wrap", {24'd0, st, cnt}, {24'd0, 4'd1, 4'h0});
    repeat (3) step();
    chk("cnt_one", 32'(cnt), 32'd1);

    // sw stalled in MEM_WR, then reset mid-wait.
    op = 6'h2B;
    step();
    step();
    step();
    rdy = 1'b0;
    #1;
    chk("sw_wr", {26'd0, st, mwr, iord}, {26'd0, 4'd6, 2'b11});
    step();
    chk("sw_wait", {27'd0, st, mwr}, {27'd0, 4'd6, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'(all_out()), 32'h0);
    chk("arst_cnt", 32'(cnt), 32'd0);
    step();
    rst_n = 1'b1;
    rdy = 1'b1;
    chk("arst_rel", 32'(st), 32'd0);
    step();
    chk("arst_fetch", 32'(st), 32'd1);
    repeat (4) step();
    chk("sw_done", {24'd0, st, cnt}, {24'd0, 4'd1, 4'd1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
